keypad_scan: RTL and testbench

Matrix-keypad front end for the calculator. Scans a 4x4 active-low key matrix, synchronises and debounces the row inputs, and encodes one press as a 4-bit key code with a one-cycle `flag` strobe. It is the producer side of the `key_value`/`flag` interface consumed by the calculator input controller: one `flag` per physical press, with no auto-repeat.

---
 rtl/calc_key_pkg.sv | 50 +++++
 rtl/row_sync.sv | 21 ++
 rtl/keypad_scan.sv | 167 ++++++++++++++++
 tb/tb_keypad_scan.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/calc_key_pkg.sv
// Shared key codes, keymap and scanner FSM states for the calculator keypad path.
package calc_key_pkg;

    localparam logic [3:0] KEY_0   = 4'h0;
    localparam logic [3:0] KEY_1   = 4'h1;
    localparam logic [3:0] KEY_2   = 4'h2;
    localparam logic [3:0] KEY_3   = 4'h3;
    localparam logic [3:0] KEY_4   = 4'h4;
    localparam logic [3:0] KEY_5   = 4'h5;
    localparam logic [3:0] KEY_6   = 4'h6;
    localparam logic [3:0] KEY_7   = 4'h7;
    localparam logic [3:0] KEY_8   = 4'h8;
    localparam logic [3:0] KEY_9   = 4'h9;
    localparam logic [3:0] KEY_ADD = 4'ha;
    localparam logic [3:0] KEY_SUB = 4'hb;
    localparam logic [3:0] KEY_MUL = 4'hc;
    localparam logic [3:0] KEY_DIV = 4'hd;
    localparam logic [3:0] KEY_EQ  = 4'he;
    localparam logic [3:0] KEY_CLR = 4'hf;

    typedef enum logic [1:0] {
        StIdle,
        StDebounce,
        StHeld
    } key_state_e;

    function automatic logic [3:0] keymap(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'h0: code = KEY_1;
            4'h1: code = KEY_2;
            4'h2: code = KEY_3;
            4'h3: code = KEY_ADD;
            4'h4: code = KEY_4;
            4'h5: code = KEY_5;
            4'h6: code = KEY_6;
            4'h7: code = KEY_SUB;
            4'h8: code = KEY_7;
            4'h9: code = KEY_8;
            4'ha: code = KEY_9;
            4'hb: code = KEY_MUL;
            4'hc: code = KEY_CLR;
            4'hd: code = KEY_0;
            4'he: code = KEY_EQ;
            default: code = KEY_DIV;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/row_sync.sv
// Two-flop synchroniser for the asynchronous keypad row lines; idles at all-released.
module row_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 4'b1111;
            q      <= 4'b1111;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: column drive, per-scan hit accumulation, debounce/release FSM
// and a single registered flag per accepted press.
module keypad_scan
    import calc_key_pkg::*;
#(
    parameter int unsigned SETTLE         = 3,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned RELEASE_SCANS  = 2
) (
    input  logic       CLK_1K,
    input  logic       RST,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_value,
    output logic       flag,
    output logic       key_down
);

    localparam int unsigned SlotW = $clog2(SETTLE + 1);
    localparam int unsigned CntW  = $clog2(DEBOUNCE_SCANS + 1);
    localparam int unsigned RelW  = $clog2(RELEASE_SCANS + 1);

    logic [SlotW-1:0] slot_q;
    logic [1:0]       col_q;
    logic [3:0]       row_s;
    logic             sample, scan_end;

    row_sync u_row_sync (
        .clk (CLK_1K),
        .rst (RST),
        .d   (row_n),
        .q   (row_s)
    );

    assign sample   = (slot_q == SlotW'(SETTLE));
    assign scan_end = sample && (col_q == 2'd3);
    assign col_n    = ~(4'b0001 << col_q);

    always_ff @(posedge CLK_1K) begin
        if (RST) begin
            slot_q <= '0;
            col_q  <= 2'd0;
        end else if (sample) begin
            slot_q <= '0;
            col_q  <= col_q + 2'd1;
        end else begin
            slot_q <= slot_q + SlotW'(1);
        end
    end

    // Hit count saturates at 2: anything beyond one hit is simply "multi".
    logic [1:0] hits_q, hits_total;
    logic [3:0] code_q, code_total;
    logic [2:0] col_hits, hit_sum;
    logic [1:0] col_row;

    always_comb begin
        col_hits = 3'd0;
        col_row  = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (!row_s[r]) begin
                col_hits = col_hits + 3'd1;
                col_row  = 2'(r);
            end
        end
        hit_sum    = {1'b0, hits_q} + col_hits;
        hits_total = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
        code_total = code_q;
        if (hits_q == 2'd0 && col_hits == 3'd1) begin
            code_total = keymap(col_row, col_q);
        end
    end

    // The FSM consumes hits_total on scan end, so clearing here loses nothing.
    always_ff @(posedge CLK_1K) begin
        if (RST || scan_end) begin
            hits_q <= 2'd0;
            code_q <= 4'h0;
        end else if (sample) begin
            hits_q <= hits_total;
            code_q <= code_total;
        end
    end

    key_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [RelW-1:0] rel_q, rel_d;
    logic [3:0]      cand_q, cand_d;
    logic [3:0]      key_value_q, key_value_d;
    logic            flag_q, flag_d;
    logic            res_none, res_single;

    assign res_none   = (hits_total == 2'd0);
    assign res_single = (hits_total == 2'd1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rel_d       = rel_q;
        cand_d      = cand_q;
        key_value_d = key_value_q;
        flag_d      = 1'b0;
        if (scan_end) begin
            case (state_q)
                StIdle: begin
                    if (res_single) begin
                        cand_d  = code_total;
                        cnt_d   = CntW'(1);
                        state_d = StDebounce;
                    end
                end
                StDebounce: begin
                    if (res_single && code_total == cand_q) begin
                        if (32'(cnt_q) + 32'd1 >= DEBOUNCE_SCANS) begin
                            cnt_d       = CntW'(DEBOUNCE_SCANS);
                            state_d     = StHeld;
                            flag_d      = 1'b1;
                            key_value_d = cand_q;
                        end else begin
                            cnt_d = cnt_q + CntW'(1);
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = StIdle;
                    end
                end
                StHeld: begin
                    if (res_none) begin
                        if (32'(rel_q) + 32'd1 >= RELEASE_SCANS) begin
                            rel_d   = '0;
                            cnt_d   = '0;
                            state_d = StIdle;
                        end else begin
                            rel_d = rel_q + RelW'(1);
                        end
                    end else begin
                        rel_d = '0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge CLK_1K) begin
        if (RST) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            rel_q       <= '0;
            cand_q      <= 4'h0;
            key_value_q <= 4'h0;
            flag_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rel_q       <= rel_d;
            cand_q      <= cand_d;
            key_value_q <= key_value_d;
            flag_q      <= flag_d;
        end
    end

    assign key_value = key_value_q;
    assign flag      = flag_q;
    assign key_down  = (state_q == StHeld);

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: physical key matrix model plus a scan-level press/release reference.
module tb_keypad_scan;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row_n, col_n, key_value;
    logic        flag, key_down;
    logic [15:0] keys = 16'h0000;  // bit r*4+c set = key at row r, col c pressed

    int checks = 0;
    int errors = 0;

    // Reference: run length of identical single-key scans while armed, empty-scan run while held.
    bit         armed     = 1'b1;
    int         streak    = 0;
    int         empty_run = 0;
    logic [3:0] cand      = 4'h0;
    logic [3:0] m_kv      = 4'h0;
    logic       m_flag    = 1'b0;

    logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'ha,
                              4'h4, 4'h5, 4'h6, 4'hb,
                              4'h7, 4'h8, 4'h9, 4'hc,
                              4'hf, 4'h0, 4'he, 4'hd};

    always #5 clk = ~clk;

    always_comb begin
        row_n = 4'hf;
        for (int r = 0; r < 4; r++) begin
            row_n[r] = ~|(keys[r*4 +: 4] & ~col_n);
        end
    end

    keypad_scan dut (
        .CLK_1K    (clk),
        .RST       (rst),
        .row_n     (row_n),
        .col_n     (col_n),
        .key_value (key_value),
        .flag      (flag),
        .key_down  (key_down)
    );

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_scan(input logic [15:0] k);
        int n;
        int idx;
        logic [3:0] code;
        n      = $countones(k);
        idx    = 0;
        m_flag = 1'b0;
        for (int i = 0; i < 16; i++) if (k[i]) idx = i;
        code = kmap[idx];
        if (armed) begin
            if (n == 1) begin
                if (streak == 0) begin
                    cand   = code;
                    streak = 1;
                end else if (code == cand) begin
                    streak++;
                end else begin
                    streak = 0;
                end
                if (streak == 4) begin
                    m_flag    = 1'b1;
                    m_kv      = cand;
                    armed     = 1'b0;
                    empty_run = 0;
                    streak    = 0;
                end
            end else begin
                streak = 0;
            end
        end else if (n == 0) begin
            empty_run++;
            if (empty_run == 2) begin
                armed     = 1'b1;
                empty_run = 0;
            end
        end else begin
            empty_run = 0;
        end
    endtask

    // Called right after the edge that starts a scan; checks every cycle of that scan.
    task automatic run_scan(input logic [15:0] k);
        logic [3:0] exp_col;
        keys = k;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            if (i == 15) model_scan(k);
            else m_flag = 1'b0;
            exp_col = 4'hf;
            exp_col[((i + 1) % 16) / 4] = 1'b0;
            check("col_n", col_n, exp_col);
            check("flag", {3'b0, flag}, {3'b0, m_flag});
            check("key_value", key_value, m_kv);
            check("key_down", {3'b0, key_down}, {3'b0, ~armed});
        end
    endtask

    // Less than a full scan, so no scan end can occur.
    task automatic partial_scan(input logic [15:0] k, input int n);
        keys = k;
        repeat (n) begin
            @(posedge clk);
            #1;
            check("flag_partial", {3'b0, flag}, 4'h0);
            check("key_down_partial", {3'b0, key_down}, {3'b0, ~armed});
        end
    endtask

    task automatic apply_reset(input logic [15:0] k, input int n);
        keys = k;
        rst  = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
            check("rst_col_n", col_n, 4'b1110);
            check("rst_flag", {3'b0, flag}, 4'h0);
            check("rst_key_value", key_value, 4'h0);
            check("rst_key_down", {3'b0, key_down}, 4'h0);
        end
        rst       = 1'b0;
        armed     = 1'b1;
        streak    = 0;
        empty_run = 0;
        m_kv      = 4'h0;
    endtask

    initial begin
        logic [15:0] k;
        int a, b, r;

        apply_reset(16'hffff, 3);
        repeat (2) run_scan(16'h0000);

        // "6" held, then released
        repeat (12) run_scan(16'h0040);
        repeat (3) run_scan(16'h0000);

        // "D" bouncing scan to scan, never four in a row, then steady
        foreach (kmap[i]) begin
            if (i < 11) run_scan(((16'h0b5d >> i) & 16'h1) != 0 ? 16'h8000 : 16'h0000);
        end
        repeat (6) run_scan(16'h8000);
        repeat (3) run_scan(16'h0000);

        // "1" and "2" together, then "2" released
        repeat (12) run_scan(16'h0003);
        repeat (6) run_scan(16'h0001);
        repeat (3) run_scan(16'h0000);

        // "E": short release must not re-arm, longer release must
        repeat (5) run_scan(16'h4000);
        run_scan(16'h0000);
        repeat (5) run_scan(16'h4000);
        repeat (3) run_scan(16'h0000);
        repeat (5) run_scan(16'h4000);
        repeat (3) run_scan(16'h0000);

        // "0" interrupted by reset mid-debounce and mid-scan
        repeat (2) run_scan(16'h2000);
        partial_scan(16'h2000, 7);
        apply_reset(16'h2000, 2);
        repeat (5) run_scan(16'h2000);
        repeat (3) run_scan(16'h0000);

        // Random sequences of none / single / multi, biased towards holding
        k = 16'h0000;
        repeat (80) begin
            r = $urandom_range(0, 9);
            if (r == 6) begin
                k = 16'h0000;
            end else if (r == 7 || r == 8) begin
                k = 16'h0001 << $urandom_range(0, 15);
            end else if (r == 9) begin
                a = $urandom_range(0, 15);
                b = (a + $urandom_range(1, 15)) % 16;
                k = (16'h0001 << a) | (16'h0001 << b);
            end
            run_scan(k);
        end
        repeat (3) run_scan(16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
